tt_clk_div_monitor: RTL

Receive-side checker for a divided feedback clock, such as the 10MHz output of the divide-by-3 generator. It samples the divided clock asynchronously in a faster monitor clock domain and measures the period and high time of each cycle. It declares lock after LOCK_CNT consecutive in-tolerance periods and flags a stuck clock. It sits beside the clock generator and feeds lock and fault status to the top-level controller.

---
 rtl/tt_clk_mon_pkg.sv | 13 +
 rtl/tt_clk_div_monitor_if.sv | 28 ++
 rtl/tt_sync_edge.sv | 29 ++
 rtl/tt_clk_div_monitor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tt_clk_mon_pkg.sv
// Shared types for the divided-clock monitors: FSM state encoding and its width.
package tt_clk_mon_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_clk_div_monitor_if.sv
// Signal bundle of tt_clk_div_monitor: clock under test, scan access, status and a state debug view.
interface tt_clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  import tt_clk_mon_pkg::*;

  logic             i_clk_div;
  logic             i_scan_en;
  logic             i_scan_in;
  logic             o_locked;
  logic             o_fault;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_scan_out;
  state_t           state;

  // No handshake: status is level-valid every cycle, the clock under test is free-running.
  modport master (
    output i_clk_div, i_scan_en, i_scan_in,
    input  o_locked, o_fault, o_period, o_high, o_scan_out, state
  );

  modport slave (
    input  i_clk_div, i_scan_en, i_scan_in,
    output o_locked, o_fault, o_period, o_high, o_scan_out, state
  );

endinterface

// File: rtl/tt_sync_edge.sv
// Two-flop synchronizer followed by an edge register; level and rise leave aligned to each other.
module tt_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;

  // level and rise are both registered from sync, so a rise is always seen with level=1
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else if (!hold) begin
      meta  <= async_in;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
    end
  end

endmodule

// File: rtl/tt_clk_div_monitor.sv
// Period/high-time monitor for a divided feedback clock with lock and stuck-clock detection.
// Optional duty-cycle qualification of good periods: define TT_DIV_MON_DUTY_CHECK_EN.
module tt_clk_div_monitor
  import tt_clk_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4
`ifdef TT_DIV_MON_DUTY_CHECK_EN
  ,
  parameter int DUTY_TOL   = 1
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  tt_clk_div_monitor_if.slave  bus
);

  localparam int               GOOD_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * EXP_PERIOD);

  state_t             state, state_nxt;
  logic [GOOD_W-1:0]  good_cnt, good_cnt_nxt;
  logic [CNT_W-1:0]   period_cnt, high_cnt;
  logic [CNT_W-1:0]   cap_period, cap_high;
  logic               locked_q, fault_q;
  logic               level, rise, hold;
  logic               period_ok, duty_ok, good, timeout, capture;
  int                 period_diff;

  assign hold = bus.i_scan_en;

  tt_sync_edge u_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .hold     (hold),
    .async_in (bus.i_clk_div),
    .level    (level),
    .rise     (rise)
  );

  always_comb begin
    period_diff = int'(period_cnt) - EXP_PERIOD;
    period_ok   = (period_diff <= TOL) && (period_diff >= -TOL);
  end

`ifdef TT_DIV_MON_DUTY_CHECK_EN
  int high_diff;
  always_comb begin
    high_diff = int'(high_cnt) - (EXP_PERIOD / 2);
    duty_ok   = (high_diff <= DUTY_TOL) && (high_diff >= -DUTY_TOL);
  end
`else
  assign duty_ok = 1'b1;
`endif

  assign good    = period_ok && duty_ok;
  assign timeout = (period_cnt >= TIMEOUT);

  // A rise always wins over a timeout landing on the same cycle.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt    = MEASURE;
          good_cnt_nxt = '0;
        end else if (timeout) begin
          state_nxt    = FAULT;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          if (!good) begin
            good_cnt_nxt = '0;
          end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
            state_nxt    = LOCKED;
            good_cnt_nxt = '0;
          end else begin
            good_cnt_nxt = good_cnt + 1'b1;
          end
        end else if (timeout) begin
          state_nxt    = FAULT;
          good_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          capture = 1'b1;
          if (!good) begin
            state_nxt    = MEASURE;
            good_cnt_nxt = '0;
          end
        end else if (timeout) begin
          state_nxt    = FAULT;
        end
      end
      FAULT: begin
        if (rise) begin
          state_nxt    = MEASURE;
          good_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        good_cnt_nxt = '0;
      end
    endcase
  end

  // While scanning, cap_period/cap_high become one shift chain and everything else holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      good_cnt   <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      cap_period <= '0;
      cap_high   <= '0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else if (hold) begin
      cap_period <= {cap_period[CNT_W-2:0], bus.i_scan_in};
      cap_high   <= {cap_high[CNT_W-2:0], cap_period[CNT_W-1]};
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      locked_q <= (state_nxt == LOCKED);
      fault_q  <= (state_nxt == FAULT);
      if (rise) begin
        period_cnt <= CNT_W'(1);
        high_cnt   <= CNT_W'(level);
      end else begin
        if (period_cnt != CNT_MAX) period_cnt <= period_cnt + 1'b1;
        if (level && (high_cnt != CNT_MAX)) high_cnt <= high_cnt + 1'b1;
      end
      if (capture) begin
        cap_period <= period_cnt;
        cap_high   <= high_cnt;
      end
    end
  end

  assign bus.o_locked   = locked_q;
  assign bus.o_fault    = fault_q;
  assign bus.o_period   = cap_period;
  assign bus.o_high     = cap_high;
  assign bus.o_scan_out = cap_high[CNT_W-1];
  assign bus.state      = state;

endmodule
